// File: rtl/roc_pkg.sv
// -----------------------------------------------------------------------------
// roc_pkg
// Shared definitions for the rank-order-coding input encoder.
//   roc_state_t  : encoder FSM states
//   NEXT_INDEX_W : width of the index handed to the AER input controller
// Optional build macro used by this block: ROC_ZERO_SKIP_EN (see roc_encoder).
// -----------------------------------------------------------------------------
package roc_pkg;

   localparam int NEXT_INDEX_W = 10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEARCH    = 3'd1,
      SEND      = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_FREE = 3'd4,
      DONE      = 3'd5
   } roc_state_t;

endpackage

// File: rtl/roc_max_finder.sv
// -----------------------------------------------------------------------------
// roc_max_finder
// Sequential masked argmax over the latched image, one pixel per cycle.
// A scan is launched by a one-cycle start pulse; pixel 0 is examined in the
// start cycle itself, so a full pass takes IMAGE_SIZE cycles and is followed by
// a one-cycle done pulse with best_idx/best_val stable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : launch a new scan (restarts any scan in progress)
//   image      : latched pixel array
//   mask       : 1 = pixel already sent, excluded from the scan
//   best_idx   : index of the largest unmasked pixel (lowest index on ties)
//   best_val   : value of that pixel
//   done       : one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module roc_max_finder
   import roc_pkg::*;
#(
   parameter int IMAGE_SIZE = 7,
   parameter int IDX_W      = 3,
   parameter int PIXEL_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [PIXEL_BITS-1:0] image [0:IMAGE_SIZE-1],
   input  logic [IMAGE_SIZE-1:0] mask,
   output logic [IDX_W-1:0]      best_idx,
   output logic [PIXEL_BITS-1:0] best_val,
   output logic                  done
);

   logic                  running_reg;
   logic [IDX_W-1:0]      cnt_reg;
   logic                  found_reg;

   logic                  active;
   logic [IDX_W-1:0]      scan_idx;
   logic [PIXEL_BITS-1:0] cand;
   logic                  have_best;
   logic                  take;
   logic                  last;

   always_comb begin
      active    = start | running_reg;
      scan_idx  = start ? '0 : cnt_reg;
      cand      = image[scan_idx];
      // A start cycle discards whatever the previous scan accumulated.
      have_best = start ? 1'b0 : found_reg;
      // The first unmasked pixel is always taken so that zero-valued pixels
      // can still win; afterwards only a strictly larger value replaces it.
      take      = active && !mask[scan_idx] && (!have_best || (cand > best_val));
      last      = (scan_idx == IDX_W'(IMAGE_SIZE - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_reg <= 1'b0;
         cnt_reg     <= '0;
         found_reg   <= 1'b0;
         best_idx    <= '0;
         best_val    <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            found_reg <= 1'b0;
            best_idx  <= '0;
            best_val  <= '0;
         end
         if (take) begin
            found_reg <= 1'b1;
            best_idx  <= scan_idx;
            best_val  <= cand;
         end
         if (active) begin
            if (last) begin
               running_reg <= 1'b0;
               cnt_reg     <= '0;
               done        <= 1'b1;
            end else begin
               running_reg <= 1'b1;
               cnt_reg     <= scan_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/roc_encoder.sv
// -----------------------------------------------------------------------------
// roc_encoder
// Rank-order-coding input encoder. Latches an image on NEW_IMAGE and emits the
// pixel indices in descending intensity order (ties: lowest index first), one
// per AER handshake. Encoding stops early on FIRST_INFERENCE_DONE.
// Ports:
//   CLK                  : clock, rising edge
//   RST                  : asynchronous active-low reset
//   IMAGE                : pixel array, sampled when NEW_IMAGE is accepted
//   NEW_IMAGE            : start request (honoured in IDLE/DONE only)
//   AERIN_CTRL_BUSY      : AER controller busy
//   FIRST_INFERENCE_DONE : abort request
//   NEXT_INDEX           : emitted pixel index, held between strobes
//   FOUND_NEXT_INDEX     : one-cycle strobe, NEXT_INDEX valid
//   ENCODER_RDY          : image fully encoded or aborted
// Build option: define ROC_ZERO_SKIP_EN to never emit zero-valued pixels; the
// encoder then finishes as soon as the best remaining value is zero.
// -----------------------------------------------------------------------------
module roc_encoder
   import roc_pkg::*;
#(
   parameter int IMAGE_SIZE      = 7,
   parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int PIXEL_MAX_VALUE = 255,
   parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [PIXEL_BITS-1:0]   IMAGE [0:IMAGE_SIZE-1],
   input  logic                    NEW_IMAGE,
   input  logic                    AERIN_CTRL_BUSY,
   input  logic                    FIRST_INFERENCE_DONE,
   output logic [NEXT_INDEX_W-1:0] NEXT_INDEX,
   output logic                    FOUND_NEXT_INDEX,
   output logic                    ENCODER_RDY
);

   // Keep the counter at least one bit wide for a degenerate one-pixel image.
   localparam int IDX_W = (IMAGE_SIZE_BITS < 1) ? 1 : IMAGE_SIZE_BITS;

`ifdef ROC_ZERO_SKIP_EN
   localparam bit ZERO_SKIP = 1'b1;
`else
   localparam bit ZERO_SKIP = 1'b0;
`endif

   roc_state_t            state_reg;
   logic [PIXEL_BITS-1:0] image_reg [0:IMAGE_SIZE-1];
   logic [IMAGE_SIZE-1:0] mask_reg;
   logic                  start_reg;

   logic                  accept;
   logic [IDX_W-1:0]      best_idx;
   logic [PIXEL_BITS-1:0] best_val;
   logic                  find_done;

   assign accept = ((state_reg == IDLE) || (state_reg == DONE)) && NEW_IMAGE;

   genvar gi;
   generate
      for (gi = 0; gi < IMAGE_SIZE; gi++) begin : g_pix
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               image_reg[gi] <= '0;
            end else if (accept) begin
               image_reg[gi] <= IMAGE[gi];
            end
         end
      end
   endgenerate

   roc_max_finder #(
      .IMAGE_SIZE (IMAGE_SIZE),
      .IDX_W      (IDX_W),
      .PIXEL_BITS (PIXEL_BITS)
   ) u_max_finder (
      .clk      (CLK),
      .rst_n    (RST),
      .start    (start_reg),
      .image    (image_reg),
      .mask     (mask_reg),
      .best_idx (best_idx),
      .best_val (best_val),
      .done     (find_done)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg        <= IDLE;
         mask_reg         <= '0;
         start_reg        <= 1'b0;
         NEXT_INDEX       <= '0;
         FOUND_NEXT_INDEX <= 1'b0;
         ENCODER_RDY      <= 1'b0;
      end else begin
         start_reg        <= 1'b0;
         FOUND_NEXT_INDEX <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (NEW_IMAGE) begin
                  mask_reg    <= '0;
                  ENCODER_RDY <= 1'b0;
                  start_reg   <= 1'b1;
                  state_reg   <= SEARCH;
               end
            end
            default: begin
               if (FIRST_INFERENCE_DONE) begin
                  state_reg   <= DONE;
                  ENCODER_RDY <= 1'b1;
               end else begin
                  case (state_reg)
                     SEARCH: begin
                        // A done pulse seen during the start cycle belongs to
                        // a scan that was interrupted by an abort; ignore it.
                        if (find_done && !start_reg) begin
                           if (ZERO_SKIP && (best_val == '0)) begin
                              state_reg   <= DONE;
                              ENCODER_RDY <= 1'b1;
                           end else begin
                              state_reg <= SEND;
                           end
                        end
                     end
                     SEND: begin
                        if (!AERIN_CTRL_BUSY) begin
                           NEXT_INDEX         <= NEXT_INDEX_W'(best_idx);
                           FOUND_NEXT_INDEX   <= 1'b1;
                           mask_reg[best_idx] <= 1'b1;
                           state_reg          <= WAIT_BUSY;
                        end
                     end
                     WAIT_BUSY: begin
                        if (AERIN_CTRL_BUSY) begin
                           state_reg <= WAIT_FREE;
                        end
                     end
                     WAIT_FREE: begin
                        if (!AERIN_CTRL_BUSY) begin
                           if (&mask_reg) begin
                              state_reg   <= DONE;
                              ENCODER_RDY <= 1'b1;
                           end else begin
                              start_reg <= 1'b1;
                              state_reg <= SEARCH;
                           end
                        end
                     end
                     default: state_reg <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_roc_encoder.sv
module tb_roc_encoder;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] IMAGE [0:6];
   logic       NEW_IMAGE = 1'b0;
   logic       FID = 1'b0;
   logic       hold_busy = 1'b0;
   logic       resp_busy = 1'b0;
   logic       BUSY;
   logic [9:0] NEXT_INDEX;
   logic       FOUND;
   logic       RDY;

   int checks   = 0;
   int failures = 0;

   int unsigned strobes [$];
   int          unstable = 0;
   logic [9:0]  prev_idx = '0;

   assign BUSY = hold_busy | resp_busy;

   always #5 CLK = ~CLK;

   roc_encoder dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .IMAGE                (IMAGE),
      .NEW_IMAGE            (NEW_IMAGE),
      .AERIN_CTRL_BUSY      (BUSY),
      .FIRST_INFERENCE_DONE (FID),
      .NEXT_INDEX           (NEXT_INDEX),
      .FOUND_NEXT_INDEX     (FOUND),
      .ENCODER_RDY          (RDY)
   );

   // Strobe recorder and NEXT_INDEX stability watcher.
   initial forever begin
      @(negedge CLK);
      if (FOUND === 1'b1) begin
         strobes.push_back(int'(NEXT_INDEX));
         $display("strobe idx=%0d t=%0t", NEXT_INDEX, $time);
      end else if (NEXT_INDEX !== prev_idx) begin
         unstable++;
      end
      prev_idx = NEXT_INDEX;
   end

   // AER controller model: busy one cycle after each strobe, for two cycles.
   initial forever begin
      @(negedge CLK);
      if (FOUND === 1'b1) begin
         @(negedge CLK);
         resp_busy = 1'b1;
         @(negedge CLK);
         @(negedge CLK);
         resp_busy = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // px holds {p6,p5,...,p0}
   task automatic start_image(input logic [55:0] px);
      @(negedge CLK);
      strobes.delete();
      for (int i = 0; i < 7; i++) IMAGE[i] = px[i*8 +: 8];
      NEW_IMAGE = 1'b1;
      @(negedge CLK);
      NEW_IMAGE = 1'b0;
   endtask

   task automatic wait_rdy(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge CLK);
         if (RDY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      checks++; if (NEXT_INDEX !== 10'd0) begin failures++; $display("FAIL reset_idx actual=%0d required=0", NEXT_INDEX); end
      checks++; if (FOUND !== 1'b0) begin failures++; $display("FAIL reset_found actual=%b required=0", FOUND); end
      checks++; if (RDY !== 1'b0) begin failures++; $display("FAIL reset_rdy actual=%b required=0", RDY); end
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (100) @(negedge CLK);
      checks++; if (strobes.size() != 0) begin failures++; $display("FAIL idle_strobes actual=%0d required=0", strobes.size()); end
      checks++; if (RDY !== 1'b0) begin failures++; $display("FAIL idle_rdy actual=%b required=0", RDY); end
      $display("test_reset done");
   endtask

   task automatic test_order;
      bit ok;
`ifdef ROC_ZERO_SKIP_EN
      int unsigned exp [$] = '{4, 1, 2, 6, 0, 5};
`else
      int unsigned exp [$] = '{4, 1, 2, 6, 0, 5, 3};
`endif
      start_image({8'd90, 8'd7, 8'd255, 8'd0, 8'd200, 8'd200, 8'd10});
      checks++; if (RDY !== 1'b0) begin failures++; $display("FAIL order_rdy_clear actual=%b required=0", RDY); end
      wait_rdy(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL order_timeout actual=no_rdy required=rdy"); end
      checks++; if (resp_busy !== 1'b0) begin failures++; $display("FAIL order_rdy_before_free actual=busy%b required=busy0", resp_busy); end
      checks++; if (strobes.size() != exp.size()) begin failures++; $display("FAIL order_count actual=%0d required=%0d", strobes.size(), exp.size()); end
      for (int k = 0; k < exp.size(); k++) begin
         checks++;
         if (k >= strobes.size() || strobes[k] != exp[k]) begin
            failures++;
            $display("FAIL order_idx%0d actual=%0d required=%0d", k, (k < strobes.size()) ? strobes[k] : 999, exp[k]);
         end
      end
      repeat (30) @(negedge CLK);
      checks++; if (strobes.size() != exp.size()) begin failures++; $display("FAIL order_extra actual=%0d required=%0d", strobes.size(), exp.size()); end
      checks++; if (RDY !== 1'b1) begin failures++; $display("FAIL order_rdy_hold actual=%b required=1", RDY); end
      $display("test_order done strobes=%0d", strobes.size());
   endtask

   task automatic test_ties;
      bit ok;
      start_image({7{8'd255}});
      wait_rdy(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ties_timeout actual=no_rdy required=rdy"); end
      checks++; if (strobes.size() != 7) begin failures++; $display("FAIL ties_count actual=%0d required=7", strobes.size()); end
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (k >= strobes.size() || strobes[k] != k) begin
            failures++;
            $display("FAIL ties_idx%0d actual=%0d required=%0d", k, (k < strobes.size()) ? strobes[k] : 999, k);
         end
      end
      $display("test_ties done strobes=%0d", strobes.size());
   endtask

   task automatic test_busy_hold;
      bit ok;
      logic [9:0] held;
      hold_busy = 1'b1;
      held = NEXT_INDEX;
      unstable = 0;
      start_image({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
      repeat (40) @(negedge CLK);
      checks++; if (strobes.size() != 0) begin failures++; $display("FAIL hold_no_strobe actual=%0d required=0", strobes.size()); end
      checks++; if (NEXT_INDEX !== held) begin failures++; $display("FAIL hold_idx_stable actual=%0d required=%0d", NEXT_INDEX, held); end
      hold_busy = 1'b0;
      wait_rdy(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL hold_timeout actual=no_rdy required=rdy"); end
      checks++; if (strobes.size() != 7) begin failures++; $display("FAIL hold_count actual=%0d required=7", strobes.size()); end
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (k >= strobes.size() || strobes[k] != 6 - k) begin
            failures++;
            $display("FAIL hold_idx%0d actual=%0d required=%0d", k, (k < strobes.size()) ? strobes[k] : 999, 6 - k);
         end
      end
      checks++; if (unstable != 0) begin failures++; $display("FAIL idx_changed_without_strobe actual=%0d required=0", unstable); end
      $display("test_busy_hold done strobes=%0d", strobes.size());
   endtask

   task automatic test_abort;
      bit ok;
      int n = 0;
      start_image({8'd90, 8'd7, 8'd255, 8'd0, 8'd200, 8'd200, 8'd10});
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (FOUND === 1'b1) n++;
         if (n == 2) break;
      end
      FID = 1'b1;
      @(negedge CLK);
      FID = 1'b0;
      checks++; if (n != 2) begin failures++; $display("FAIL abort_reach2 actual=%0d required=2", n); end
      repeat (60) @(negedge CLK);
      checks++; if (strobes.size() != 2) begin failures++; $display("FAIL abort_count actual=%0d required=2", strobes.size()); end
      checks++; if (strobes.size() < 2 || strobes[0] != 4 || strobes[1] != 1) begin failures++; $display("FAIL abort_order actual=%0d,%0d required=4,1", (strobes.size() > 0) ? strobes[0] : 999, (strobes.size() > 1) ? strobes[1] : 999); end
      checks++; if (RDY !== 1'b1) begin failures++; $display("FAIL abort_rdy actual=%b required=1", RDY); end
      start_image({7{8'd255}});
      checks++; if (RDY !== 1'b0) begin failures++; $display("FAIL restart_rdy_clear actual=%b required=0", RDY); end
      wait_rdy(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL restart_timeout actual=no_rdy required=rdy"); end
      checks++; if (strobes.size() != 7) begin failures++; $display("FAIL restart_count actual=%0d required=7", strobes.size()); end
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (k >= strobes.size() || strobes[k] != k) begin
            failures++;
            $display("FAIL restart_idx%0d actual=%0d required=%0d", k, (k < strobes.size()) ? strobes[k] : 999, k);
         end
      end
      $display("test_abort done");
   endtask

   task automatic test_reset_midop;
      int n = 0;
      start_image({8'd90, 8'd7, 8'd255, 8'd0, 8'd200, 8'd200, 8'd10});
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (FOUND === 1'b1) n++;
         if (n == 1) break;
      end
      checks++; if (n != 1) begin failures++; $display("FAIL midrst_reach1 actual=%0d required=1", n); end
      RST = 1'b0;
      #1;
      checks++; if (NEXT_INDEX !== 10'd0 || RDY !== 1'b0) begin failures++; $display("FAIL midrst_outputs actual=idx%0d rdy%b required=idx0 rdy0", NEXT_INDEX, RDY); end
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      strobes.delete();
      repeat (60) @(negedge CLK);
      checks++; if (strobes.size() != 0 || RDY !== 1'b0) begin failures++; $display("FAIL midrst_idle actual=strobes%0d rdy%b required=strobes0 rdy0", strobes.size(), RDY); end
      $display("test_reset_midop done");
   endtask

   task automatic test_zero_pixels;
      bit ok;
`ifdef ROC_ZERO_SKIP_EN
      int unsigned exp [$] = '{2};
`else
      int unsigned exp [$] = '{2, 0, 1, 3, 4, 5, 6};
`endif
      start_image({8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0});
      wait_rdy(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL zero_timeout actual=no_rdy required=rdy"); end
      checks++; if (strobes.size() != exp.size()) begin failures++; $display("FAIL zero_count actual=%0d required=%0d", strobes.size(), exp.size()); end
      for (int k = 0; k < exp.size(); k++) begin
         checks++;
         if (k >= strobes.size() || strobes[k] != exp[k]) begin
            failures++;
            $display("FAIL zero_idx%0d actual=%0d required=%0d", k, (k < strobes.size()) ? strobes[k] : 999, exp[k]);
         end
      end
      start_image({7{8'd0}});
      wait_rdy(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL allzero_timeout actual=no_rdy required=rdy"); end
`ifdef ROC_ZERO_SKIP_EN
      checks++; if (strobes.size() != 0) begin failures++; $display("FAIL allzero_count actual=%0d required=0", strobes.size()); end
`else
      checks++; if (strobes.size() != 7) begin failures++; $display("FAIL allzero_count actual=%0d required=7", strobes.size()); end
`endif
      $display("test_zero_pixels done");
   endtask

   initial begin
      for (int i = 0; i < 7; i++) IMAGE[i] = 8'd0;
      test_reset();
      test_order();
      test_ties();
      test_busy_hold();
      test_abort();
      test_reset_midop();
      test_zero_pixels();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/roc_encoder.md
Name: roc_encoder

Overview:
- Rank-order-coding (ROC) input encoder for the SNN accelerator.
- Latches an image of IMAGE_SIZE pixels and emits pixel indices one at a time in descending intensity order.
- Each index is handed to the AER input controller with a pulse/busy handshake.
- Sits between the image source and the AERIN controller; stops early when the first inference is reported done.

Parameters:
IMAGE_SIZE, 7, number of pixels in the image
IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), width of internal index counters (must be <=10)
PIXEL_MAX_VALUE, 255, largest pixel value
PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), pixel width (8 at default)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
IMAGE  in  [PIXEL_BITS-1:0] x IMAGE_SIZE (unpacked [0:IMAGE_SIZE-1])  image pixels; sampled only on NEW_IMAGE acceptance
NEW_IMAGE  in  1  one-cycle request to start encoding IMAGE
AERIN_CTRL_BUSY  in  1  AER controller busy; high while consuming an index
FIRST_INFERENCE_DONE  in  1  network produced its first output; abort encoding
NEXT_INDEX  out  10  index of the current highest remaining pixel, zero-extended
FOUND_NEXT_INDEX  out  1  one-cycle strobe: NEXT_INDEX is valid
ENCODER_RDY  out  1  image fully encoded or aborted (done flag)

Behaviour:
- Reset (RST low, async): state IDLE, NEXT_INDEX=0, FOUND_NEXT_INDEX=0, ENCODER_RDY=0, sent-mask cleared, image register cleared.
- States: IDLE, SEARCH, SEND, WAIT_BUSY, WAIT_FREE, DONE.
- IDLE/DONE + NEW_IMAGE=1 at a clock edge:
  - Latch IMAGE into the internal image register.
  - Clear the sent-mask.
  - Clear ENCODER_RDY on that same edge.
  - Go to SEARCH.
- NEW_IMAGE is ignored in every other state.
- SEARCH: sequential scan, one pixel per cycle, i=0..IMAGE_SIZE-1.
  - Skips pixels already in the sent-mask.
  - Keeps the maximum value; a candidate replaces the current best only if strictly greater, so ties resolve to the lowest index.
  - Takes IMAGE_SIZE cycles, then goes to SEND.
- SEND: waits for AERIN_CTRL_BUSY=0.
  - Then drives NEXT_INDEX=best index and FOUND_NEXT_INDEX=1 for exactly one cycle.
  - Sets the mask bit for that index.
  - Goes to WAIT_BUSY.
- NEXT_INDEX holds its value until the next strobe.
- WAIT_BUSY: waits until AERIN_CTRL_BUSY=1, then goes to WAIT_FREE.
- WAIT_FREE: waits until AERIN_CTRL_BUSY=0.
  - If all IMAGE_SIZE indices have been sent: go to DONE, ENCODER_RDY=1.
  - Otherwise: go to SEARCH.
- DONE: ENCODER_RDY stays 1 until a new image is accepted.
- Total emitted: exactly IMAGE_SIZE strobes per image; zero-valued pixels are emitted last.
- FIRST_INFERENCE_DONE=1 in any non-IDLE/DONE state:
  - Next state is DONE and ENCODER_RDY=1.
  - No further strobes.
  - A strobe cycle coinciding with abort is still completed.
- FIRST_INFERENCE_DONE has priority over a pending SEND.
- Simultaneous NEW_IMAGE and FIRST_INFERENCE_DONE in DONE: NEW_IMAGE wins.
- Reset mid-operation discards all progress.

Optional Feature:
- Macro: ROC_ZERO_SKIP_EN.
- When defined, pixels with value 0 are never emitted. Encoding completes (DONE, ENCODER_RDY=1) once the best remaining value found by SEARCH is 0, or all pixels are sent.
- An all-zero image goes straight to DONE after one SEARCH pass with no strobes.
- Without the macro, all IMAGE_SIZE indices are always emitted.

Decomposition:
- Package roc_pkg: state enum (IDLE, SEARCH, SEND, WAIT_BUSY, WAIT_FREE, DONE) and NEXT_INDEX_W=10.
- One natural sub-module, roc_max_finder: sequential masked argmax over the image register. Outputs best index, best value and a done pulse.
- Top level holds the FSM, sent-mask and AER handshake.

Test Plan:
1. Reset check: RST low -> all outputs 0; after release with no NEW_IMAGE, no strobe for 100 cycles.
2. Image {10,200,200,0,255,7,90} + NEW_IMAGE pulse; AER busy 1 cycle after each strobe for 2 cycles -> strobes in order 4,1,2,6,0,5,3; 7 strobes total; ENCODER_RDY rises after the last busy falls.
3. All pixels 255 -> order 0,1,2,3,4,5,6 (ties lowest first).
4. Hold AERIN_CTRL_BUSY=1 before the first strobe -> no strobe until busy drops; NEXT_INDEX stable between strobes.
5. FIRST_INFERENCE_DONE pulsed after the 2nd strobe -> no 3rd strobe; ENCODER_RDY=1; a new NEW_IMAGE restarts from an empty mask.
6. With ROC_ZERO_SKIP_EN, image {0,0,5,0,0,0,0} -> single strobe index 2, then ENCODER_RDY=1.
